// File: rtl/golden_nonce_arbiter_pkg.sv
// rtl/golden_nonce_arbiter_pkg.sv - shared widths, defaults and sequencer states for the nonce arbiter
package golden_nonce_arbiter_pkg;

    localparam int NONCE_W            = 32;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_GUARD = 2'd1,
        SEQ_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/golden_nonce_arbiter_nonce_fifo.sv
// rtl/golden_nonce_arbiter_nonce_fifo.sv - synchronous nonce FIFO with occupancy, full and empty
module nonce_fifo
    import golden_nonce_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [NONCE_W-1:0] push_data,
    input  logic               pop,
    output logic [NONCE_W-1:0] head,
    output logic [AW:0]        count,
    output logic               full,
    output logic               empty
);

    logic [NONCE_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_ok;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// rtl/golden_nonce_arbiter.sv - captures golden nonces from all cores and serialises them to one transmitter
module golden_nonce_arbiter
    import golden_nonce_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int FIFO_AW    = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         core_valid,
    input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
    input  logic                         tx_busy,
    output logic                         tx_send,
    output logic [NONCE_W-1:0]           tx_word,
    output logic [FIFO_AW:0]             fifo_count,
    output logic                         overflow
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] cap_full;
    logic [NONCE_W-1:0]   cap_data [NUM_CORES];
    logic [PW-1:0]        rr_ptr;
    logic                 grant_valid;
    logic [PW-1:0]        grant_idx;
    logic [NUM_CORES-1:0] grant_hit;
    logic [PW:0]          cand;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [NONCE_W-1:0]   fifo_head;
    logic                 pop;
    logic [NONCE_W-1:0]   word_q;
    seq_state_t           state_q;
    seq_state_t           state_d;

    // Round-robin search: first full capture register at or after rr_ptr, only when the FIFO has room.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                cand = {1'b0, rr_ptr} + (PW+1)'(k);
                if (cand >= (PW+1)'(NUM_CORES)) begin
                    cand = cand - (PW+1)'(NUM_CORES);
                end
                if (!grant_valid && cap_full[cand[PW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[PW-1:0];
                end
            end
        end
    end

    // One-hot view of the grant for the per-core capture logic.
    always_comb begin
        grant_hit = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_valid && (grant_idx == PW'(i))) begin
                grant_hit[i] = 1'b1;
            end
        end
    end

    // Capture occupancy and the sticky loss flag; a granted slot may reload in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_full <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (grant_hit[i]) begin
                    cap_full[i] <= core_valid[i];
                end else if (core_valid[i]) begin
                    if (!cap_full[i]) begin
                        cap_full[i] <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    // Capture data; a strobe into an occupied, ungranted slot is dropped so the older nonce survives.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_valid[i] && (!cap_full[i] || grant_hit[i])) begin
                cap_data[i] <= core_nonce[NONCE_W*i +: NONCE_W];
            end
        end
    end

    // Round-robin pointer advances past whichever core was just served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == PW'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_valid),
        .push_data (cap_data[grant_idx]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequencer state register and the word held for the transmitter after each pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                word_q <= fifo_head;
            end
        end
    end

    // Send sequencing: GUARD skips the cycle where tx_busy has not yet reflected our send.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = SEQ_GUARD;
                end
            end
            SEQ_GUARD: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (!tx_busy) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    assign tx_send = pop;
    assign tx_word = pop ? fifo_head : word_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// tb/tb_golden_nonce_arbiter.sv - directed self-checking bench for golden_nonce_arbiter
module tb_golden_nonce_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   core_valid = '0;
    logic [127:0] core_nonce = '0;
    logic         tx_busy = 1'b0;
    logic         tx_send;
    logic [31:0]  tx_word;
    logic [3:0]   fifo_count;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;
    int cyc_total = 0;
    int n_sends;
    logic [31:0] rx_q [$];
    int          rx_cyc [$];
    logic [31:0] obs_w;

    golden_nonce_arbiter #(
        .NUM_CORES  (4),
        .FIFO_DEPTH (8),
        .FIFO_AW    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_valid (core_valid),
        .core_nonce (core_nonce),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_word    (tx_word),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_total++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_nonce(input int c, input logic [31:0] v);
        core_nonce[32*c +: 32] = v;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        core_valid = '0;
        core_nonce = '0;
        tx_busy    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Acts as the transmitter: busy for busy_len cycles after each sampled send.
    task automatic collect(input string tag, input int n, input int busy_len, input int budget);
        int got  = 0;
        int bcnt = 0;
        int cyc  = 0;
        rx_q.delete();
        rx_cyc.delete();
        while (got < n && cyc < budget) begin
            tick();
            cyc++;
            core_valid = '0;
            tx_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
            settle();
            if (tx_send) begin
                chk({tag, "_send_while_busy"}, 32'(tx_busy), 32'd0);
                rx_q.push_back(tx_word);
                rx_cyc.push_back(cyc_total);
                got++;
                bcnt = busy_len;
            end
        end
        chk({tag, "_word_count"}, got, n);
    endtask

    task automatic chk_word(input string tag, input int i, input logic [31:0] exp);
        obs_w = (i < rx_q.size()) ? rx_q[i] : 32'hxxxx_xxxx;
        chk(tag, obs_w, exp);
    endtask

    initial begin
        // ---- reset state and single nonce ----
        do_reset();
        settle();
        chk("rst_tx_send", 32'(tx_send), 32'd0);
        chk("rst_tx_word", tx_word, 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        core_valid = 4'b0100;
        set_nonce(2, 32'hDEADBEEF);
        settle();
        chk("t1_no_send_strobe_cycle", 32'(tx_send), 32'd0);
        tick();
        core_valid = '0;
        settle();
        chk("t1_fifo_empty_capture_cycle", 32'(fifo_count), 32'd0);
        tick();
        settle();
        chk("t1_tx_send", 32'(tx_send), 32'd1);
        chk("t1_tx_word", tx_word, 32'hDEADBEEF);
        chk("t1_fifo_count_one", 32'(fifo_count), 32'd1);
        n_sends = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            tx_busy = 1'b1;
            settle();
            if (tx_send) n_sends++;
        end
        chk("t1_no_send_while_busy", n_sends, 0);
        chk("t1_fifo_drained", 32'(fifo_count), 32'd0);
        chk("t1_word_held", tx_word, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            tx_busy = 1'b0;
            settle();
            if (tx_send) n_sends++;
        end
        chk("t1_no_second_send", n_sends, 0);

        // ---- simultaneous strobes, round-robin from pointer 0 ----
        do_reset();
        core_valid = 4'hF;
        for (int c = 0; c < 4; c++) set_nonce(c, 32'h11111111 * (c + 1));
        collect("t2", 4, 1, 60);
        for (int i = 0; i < 4; i++) chk_word("t2_order", i, 32'h11111111 * (i + 1));
        chk("t2_min_spacing", (rx_cyc.size() >= 2) ? rx_cyc[1] - rx_cyc[0] : -1, 3);
        chk("t2_overflow", 32'(overflow), 32'd0);

        // ---- fairness: core0 every cycle, core3 once ----
        do_reset();
        tx_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            core_valid = (k == 0) ? 4'b1001 : 4'b0001;
            set_nonce(0, 32'hA0000000 + k);
            if (k == 0) set_nonce(3, 32'hD3D3D3D3);
            settle();
            if (k == 2) chk("t3_overflow_before_drop", 32'(overflow), 32'd0);
            if (k == 3) begin
                chk("t3_overflow_after_drop", 32'(overflow), 32'd1);
                chk("t3_fifo_count_two", 32'(fifo_count), 32'd2);
            end
        end
        tick();
        core_valid = '0;
        tick();
        settle();
        chk("t3_fifo_count_six", 32'(fifo_count), 32'd6);
        collect("t3", 6, 2, 100);
        chk_word("t3_w0", 0, 32'hA0000000);
        chk_word("t3_w1_core3", 1, 32'hD3D3D3D3);
        chk_word("t3_w2", 2, 32'hA0000001);
        chk_word("t3_w3", 3, 32'hA0000003);
        chk_word("t3_w4", 4, 32'hA0000004);
        chk_word("t3_w5", 5, 32'hA0000005);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // ---- backpressure: 8 in FIFO, 4 held in captures ----
        do_reset();
        tx_busy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            core_valid = 4'hF;
            for (int c = 0; c < 4; c++) set_nonce(c, 32'hB0000000 | (r << 4) | c);
            tick();
            core_valid = '0;
            if (r < 2) repeat (4) tick();
        end
        settle();
        chk("t4_fifo_full_count", 32'(fifo_count), 32'd8);
        chk("t4_no_overflow_when_full", 32'(overflow), 32'd0);
        tick();
        core_valid = 4'b0010;
        set_nonce(1, 32'hBAD00001);
        settle();
        chk("t4_overflow_pre", 32'(overflow), 32'd0);
        tick();
        core_valid = '0;
        settle();
        chk("t4_overflow_set", 32'(overflow), 32'd1);
        chk("t4_fifo_still_full", 32'(fifo_count), 32'd8);
        collect("t4", 12, 1, 200);
        for (int i = 0; i < 12; i++) chk_word("t4_order", i, 32'hB0000000 | ((i / 4) << 4) | (i % 4));
        tick();
        settle();
        chk("t4_fifo_drained", 32'(fifo_count), 32'd0);

        // ---- same-cycle grant and reload on one core ----
        do_reset();
        tx_busy = 1'b1;
        core_valid = 4'b0010;
        set_nonce(1, 32'h5A5A0001);
        tick();
        core_valid = 4'b0010;
        set_nonce(1, 32'h5A5A0002);
        tick();
        core_valid = '0;
        tick();
        settle();
        chk("t5_fifo_count", 32'(fifo_count), 32'd2);
        chk("t5_overflow", 32'(overflow), 32'd0);
        collect("t5", 2, 1, 50);
        chk_word("t5_first", 0, 32'h5A5A0001);
        chk_word("t5_second", 1, 32'h5A5A0002);
        chk("t5_overflow_after", 32'(overflow), 32'd0);

        // ---- reset while waiting on a busy transmitter ----
        do_reset();
        core_valid = 4'b0001;
        set_nonce(0, 32'h6E6E0001);
        tick();
        core_valid = '0;
        tick();
        core_valid = 4'b0010;
        set_nonce(1, 32'h6E6E0002);
        settle();
        chk("t6_send", 32'(tx_send), 32'd1);
        chk("t6_word", tx_word, 32'h6E6E0001);
        tick();
        core_valid = '0;
        tx_busy = 1'b1;
        tick();
        settle();
        chk("t6_queued", 32'(fifo_count), 32'd1);
        chk("t6_no_send_wait", 32'(tx_send), 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        core_valid = 4'b0100;
        set_nonce(2, 32'h6E6E0003);
        settle();
        chk("t6_rst_tx_send", 32'(tx_send), 32'd0);
        chk("t6_rst_tx_word", tx_word, 32'd0);
        chk("t6_rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        tick();
        core_valid = '0;
        tick();
        settle();
        chk("t6_new_queued", 32'(fifo_count), 32'd1);
        chk("t6_held_by_busy", 32'(tx_send), 32'd0);
        tick();
        tx_busy = 1'b0;
        settle();
        chk("t6_send_after_idle", 32'(tx_send), 32'd1);
        chk("t6_word_after_idle", tx_word, 32'h6E6E0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/golden_nonce_arbiter.md
Name: golden_nonce_arbiter

Overview:
- Shares the single serial transmitter between NUM_CORES hashing cores that report golden nonces.
- Each core gets a one-entry capture register.
- A round-robin arbiter moves captured nonces into a small FIFO.
- A send sequencer drains the FIFO into the transmitter's send/word/busy handshake, one 32-bit word per transmission.

Parameters:
- NUM_CORES, 4, number of requesting hash cores (1..8).
- FIFO_DEPTH, 8, nonce FIFO entries; power of two, ≥2.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single system clock, also the transmitter clock.
- rst_n  in  1  synchronous active-low reset.
- core_valid  in  NUM_CORES  per-core one-cycle golden-nonce strobe.
- core_nonce  in  32*NUM_CORES  core i nonce on bits [32i+31:32i]; sampled with core_valid[i].
- tx_busy  in  1  transmitter busy, high while a 4-byte word is in flight.
- tx_send  out  1  one-cycle send request to the transmitter.
- tx_word  out  32  word to transmit; valid when tx_send=1.
- fifo_count  out  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a nonce was lost.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - tx_send=0, tx_word=0, fifo_count=0, overflow=0.
  - All capture registers empty; round-robin pointer=0; sequencer in IDLE.
  - Reset mid-transmission abandons the sequencer only. The transmitter finishes its current word independently, and the sequencer waits for tx_busy=0 before the first new send.
- Capture stage:
  - core_valid[i]=1 with capture[i] empty: load core_nonce slice, mark full next cycle.
  - core_valid[i]=1 with capture[i] full and not granted this cycle: drop the new nonce, keep the old one, set overflow.
  - core_valid[i]=1 in the same cycle capture[i] is granted: load the new nonce, capture stays full, no loss.
- Arbiter:
  - Each cycle, if FIFO is not full, grant the first full capture register at or after rr_ptr (modulo NUM_CORES).
  - Push its nonce into the FIFO and clear it. Then rr_ptr = granted index + 1 (mod NUM_CORES).
  - At most one grant per cycle. No grant while full (capture registers hold, backpressure).
  - Capture to FIFO latency is 1 cycle: a nonce strobed at cycle T is in the FIFO at T+2 if uncontended.
- FIFO:
  - Synchronous, registered pointers, FIFO_AW+1-bit occupancy; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged and are legal even when full.
  - Pop from empty never occurs; the sequencer checks fifo_count≠0.
- Sequencer states:
  - IDLE: if fifo_count≠0 and tx_busy=0, pop head to tx_word, assert tx_send for exactly one cycle, go to GUARD.
  - GUARD: unconditional single cycle. The transmitter registers busy on the edge it samples send, so tx_busy is not trusted until the following cycle. Go to WAIT.
  - WAIT: stay while tx_busy=1; on tx_busy=0 go to IDLE.
  - Minimum spacing between tx_send pulses is 3 cycles.
- tx_word is held stable from the tx_send cycle until the next pop.
- tx_send is never high while tx_busy=1.
- overflow clears only on reset. A FIFO-full condition alone never sets it; capture registers absorb the backpressure.

Decomposition:
- Shared package/header: NONCE_W=32, sequencer state encodings (IDLE, GUARD, WAIT), default FIFO_DEPTH.
- One natural sub-module: nonce_fifo (parameterised synchronous FIFO with count, full and empty outputs).
- Round-robin grant and sequencer stay in the top.

Test Plan:
- Single nonce: core_valid[2]=1, core_nonce slice 2=32'hDEADBEEF, tx_busy idle → tx_send pulse 2 cycles later with tx_word=DEADBEEF. Hold tx_busy high 40 cycles → no second send; fifo_count returns 0.
- Simultaneous: all four cores strobe in one cycle, nonces 11111111..44444444, rr_ptr=0 → transmitted in order 1,2,3,4; each tx_send only after tx_busy falls; overflow=0.
- Fairness: core0 strobes every cycle while core3 strobes once → core3 granted within 4 cycles; core0's extra nonces set overflow=1.
- Backpressure: tx_busy held high, 8 nonces fill FIFO, 4 more held in captures → fifo_count=8, overflow=0. A fifth strobe on an already-full core sets overflow=1. Release tx_busy → 12 words sent, oldest first.
- Same-cycle grant and reload on one core: both nonces delivered, overflow stays 0.
- Reset mid-WAIT with tx_busy=1: rst_n low 1 cycle → outputs at reset values; no tx_send until tx_busy=0 and a new nonce arrives.
